mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single shared memory port between two requesters: the control path (instruction fetch, LDB/LDW/STB/STW, TRAP vector read) and a DMA/debug loader port.
- Sits between the requesters and the memory. It drives the memory strobes (rd, wr, ctrl byte/word), address and write data.
- Returns read data and a one-cycle acknowledge to the winning requester.
- CPU has priority by default. A starvation counter guarantees DMA progress.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 2, number of cycles the memory strobes are held per access (legal range 1..15).
- STARVE_LIM, 3, number of consecutive CPU grants while DMA is waiting after which DMA wins the next arbitration (legal range 1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- global_reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_ctrl  in  1  1 = word, 0 = byte.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  registered read data.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req, dma_wr, dma_ctrl, dma_addr, dma_wdata, dma_rdata, dma_ack: same widths and semantics as the cpu_* ports.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_ctrl  out  1  1 = word, 0 = byte.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid in the last strobe cycle.
- busy  out  1  high whenever the state is not IDLE.
- owner  out  1  0 = CPU, 1 = DMA; valid while busy.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state = IDLE; all strobes, acks and busy = 0.
  - rdata outputs = 0; mem_addr and mem_wdata = 0; owner = 0.
  - Latency counter = 0; starvation counter = 0.
  - Reset asserted mid-access drops the strobes on that same edge. No ack is issued.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: remain in IDLE.
  - On the edge where a request is sampled, latch the winner's wr, ctrl, addr and wdata into the mem_* outputs, set owner, load the latency counter with MEM_LAT-1, and go to ACCESS.
- Arbitration (evaluated in IDLE only):
  - Only one requester active: that requester wins.
  - Both active: DMA wins if starve_cnt == STARVE_LIM; otherwise CPU wins.
  - starve_cnt increments when CPU wins while dma_req is high, saturating at STARVE_LIM.
  - starve_cnt clears when DMA wins, or when dma_req is low in IDLE.
- ACCESS:
  - mem_rd = ~wr_latched; mem_wr = wr_latched; mem_ctrl, mem_addr and mem_wdata are held stable.
  - Counter decrements each cycle. On the cycle the counter is 0:
    - reads capture mem_rdata into the owner's rdata register;
    - go to ACK.
- ACK:
  - Strobes = 0.
  - The owner's ack = 1 for exactly this cycle; the owner's rdata is valid from this cycle until the next capture.
  - Next state is IDLE.
- Timing and throughput:
  - Request sampled at edge 0 → strobes high for cycles 1..MEM_LAT → ack in cycle MEM_LAT+1.
  - One access per MEM_LAT+2 cycles.
- Requester rules:
  - The addr, wdata, wr and ctrl inputs are sampled only at grant; later changes are ignored.
  - A requester that drops req during ACCESS still receives its ack, and the access still completes. The requester ignores the ack.
  - The requester must deassert req in the ACK cycle unless it wants a back-to-back access. A req still high in the following IDLE is treated as a new request.
- Invariants:
  - mem_rd and mem_wr are never both 1.
  - cpu_ack and dma_ack are never both 1.
  - The non-owner's rdata is unchanged.
- Byte reads: the full mem_rdata word is passed through. Byte lane selection remains the register file's responsibility (d8_d16).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Fixed priority and the starvation counter are removed.
  - When both requesters are active, the requester that did not win the last grant wins.
  - The last-winner flag resets to DMA, so the CPU wins the first contention after reset.
- Undefined: CPU priority with the STARVE_LIM guard, as specified above.

Test Plan:
1. MEM_LAT=2, reset, then CPU read of addr 0x0040 with mem_rdata=0xBEEF → mem_rd high in cycles 1–2 with mem_addr=0x0040 and mem_ctrl=cpu_ctrl; cpu_ack pulses in cycle 3; cpu_rdata=0xBEEF; busy returns to 0 in cycle 4.
2. CPU byte write (ctrl=0) of 0x00A5 to 0x0101 while dma_req is low → mem_wr=1, mem_ctrl=0, mem_wdata=0x00A5, mem_rd stays 0; dma_ack stays 0.
3. STARVE_LIM=3, cpu_req and dma_req held continuously → grant order CPU, CPU, CPU, DMA, CPU, CPU, CPU, DMA; no grant gaps beyond the MEM_LAT+2 period.
4. DMA read granted, then global_reset asserted in the first ACCESS cycle → on the next edge mem_rd=0 and busy=0; no dma_ack; dma_rdata=0.
5. CPU drops cpu_req in the middle of ACCESS → access completes and cpu_ack still pulses once; with no further requests the block stays IDLE.
6. With ARB_ROUND_ROBIN_EN defined and both requesters held → grants alternate CPU, DMA, CPU, DMA, starting with CPU after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter: CPU control path vs. DMA/debug loader.
// Define ARB_ROUND_ROBIN_EN to swap CPU priority + starvation guard for round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic              cpu_ctrl,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic              dma_ctrl,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_ctrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  // state  | meaning
  // IDLE   | arbitrate; latch winner's command on grant
  // ACCESS | strobes held for MEM_LAT cycles; read data captured on the last
  // ACK    | strobes low, one-cycle ack to the owner
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic              ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              grant_cpu, grant_dma;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // last_q = 1 means DMA won last, so CPU takes the next contention
  assign grant_cpu = cpu_req & (~dma_req | last_q);
  assign grant_dma = dma_req & ~grant_cpu;
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  logic [3:0] starve_q, starve_d;

  assign grant_cpu = cpu_req & ~(dma_req & (starve_q == STARVE_MAX));
  assign grant_dma = dma_req & ~grant_cpu;
`endif

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    ctrl_d      = ctrl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`else
    starve_d    = starve_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_cpu || grant_dma) begin
          owner_d = grant_dma;
          wr_d    = grant_dma ? dma_wr    : cpu_wr;
          ctrl_d  = grant_dma ? dma_ctrl  : cpu_ctrl;
          addr_d  = grant_dma ? dma_addr  : cpu_addr;
          wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          lat_d   = LAT_LOAD;
          state_d = S_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = grant_dma;
`endif
        end
`ifndef ARB_ROUND_ROBIN_EN
        if (!dma_req || grant_dma) begin
          starve_d = '0;
        end else if (grant_cpu && starve_q != STARVE_MAX) begin
          starve_d = starve_q + 4'd1;
        end
`endif
      end
      S_ACCESS: begin
        if (lat_q == '0) begin
          if (!wr_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = S_ACK;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      ctrl_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      ctrl_q      <= ctrl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign mem_rd    = (state_q == S_ACCESS) & ~wr_q;
  assign mem_wr    = (state_q == S_ACCESS) &  wr_q;
  assign mem_ctrl  = ctrl_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == S_ACK) & ~owner_q;
  assign dma_ack   = (state_q == S_ACK) &  owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected accesses,
// acks and per-cycle probes; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_LIM = 3;

  logic        clk = 1'b0;
  logic        global_reset;
  logic        cpu_req, cpu_wr, cpu_ctrl, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_wr, dma_ctrl, dma_ack;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_rd, mem_wr, mem_ctrl, busy, owner;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .global_reset(global_reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_ctrl(cpu_ctrl), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_ctrl(dma_ctrl), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // memory model: one fixed word, everything else address-derived
  assign mem_rdata = (mem_addr == 16'h0040) ? 16'hBEEF : (mem_addr ^ 16'h5A5A);

  typedef struct {
    bit          own;
    bit          wr;
    bit          ctrl;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          gap;
  } txn_t;

  typedef struct {
    string       nm;
    int          cyc;
    int          sel;
    logic [15:0] exp;
  } probe_t;

  localparam int P_RD = 0, P_WR = 1, P_ACKC = 2, P_ACKD = 3, P_BUSY = 4, P_OWN = 5,
                 P_CRD = 6, P_DRD = 7, P_ADDR = 8, P_WDATA = 9, P_CTRL = 10;

  txn_t   acc_q[$];
  txn_t   ack_q[$];
  probe_t prb_q[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     done = 0;
  bit     reported = 0;

  function automatic logic [15:0] probe_val(input int s);
    case (s)
      P_RD:    return {15'd0, mem_rd};
      P_WR:    return {15'd0, mem_wr};
      P_ACKC:  return {15'd0, cpu_ack};
      P_ACKD:  return {15'd0, dma_ack};
      P_BUSY:  return {15'd0, busy};
      P_OWN:   return {15'd0, owner};
      P_CRD:   return cpu_rdata;
      P_DRD:   return dma_rdata;
      P_ADDR:  return mem_addr;
      P_WDATA: return mem_wdata;
      P_CTRL:  return {15'd0, mem_ctrl};
      default: return 16'hxxxx;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor
  initial begin
    logic [15:0] mdl_crd, mdl_drd;
    bit          stb, stb_prev;
    int          stb_len, last_ack;
    txn_t        t;
    probe_t      p;
    mdl_crd = '0; mdl_drd = '0; stb_prev = 0; stb_len = 0; last_ack = 0;
    forever begin
      @(negedge clk);
      if (global_reset) begin
        mdl_crd = '0;
        mdl_drd = '0;
      end
      if (mem_rd && mem_wr) begin
        n_bad++;
        $display("FAIL strobe_excl cyc=%0d: rd=1 wr=1, required not both", cyc);
      end
      if (cpu_ack && dma_ack) begin
        n_bad++;
        $display("FAIL ack_excl cyc=%0d: both acks high, required at most one", cyc);
      end
      stb = mem_rd | mem_wr;
      if (stb && !stb_prev) begin
        stb_len = 0;
        n_cmp++;
        if (acc_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_access cyc=%0d addr=%h", cyc, mem_addr);
        end else begin
          t = acc_q.pop_front();
          if ({mem_rd, mem_wr, owner, mem_ctrl, mem_addr, mem_wdata} !==
              {~t.wr, t.wr, t.own, t.ctrl, t.addr, t.wdata})
            begin
              n_bad++;
              $display("FAIL access cyc=%0d: got rd=%b wr=%b own=%b ctrl=%b addr=%h wd=%h, need rd=%b wr=%b own=%b ctrl=%b addr=%h wd=%h",
                       cyc, mem_rd, mem_wr, owner, mem_ctrl, mem_addr, mem_wdata,
                       ~t.wr, t.wr, t.own, t.ctrl, t.addr, t.wdata);
            end
        end
      end
      if (stb) stb_len++;
      stb_prev = stb;
      if (cpu_ack || dma_ack) begin
        n_cmp++;
        if (ack_q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_ack cyc=%0d cpu_ack=%b dma_ack=%b", cyc, cpu_ack, dma_ack);
        end else begin
          t = ack_q.pop_front();
          if ({dma_ack, cpu_ack} !== {t.own, ~t.own}) begin
            n_bad++;
            $display("FAIL ack_owner cyc=%0d: got dma_ack=%b cpu_ack=%b, need owner=%b", cyc, dma_ack, cpu_ack, t.own);
          end
          n_cmp++;
          if (stb_len != MEM_LAT) begin
            n_bad++;
            $display("FAIL strobe_len cyc=%0d: got %0d, need %0d", cyc, stb_len, MEM_LAT);
          end
          if (!t.wr) begin
            if (t.own) mdl_drd = t.rdata;
            else       mdl_crd = t.rdata;
          end
          n_cmp++;
          if (cpu_rdata !== mdl_crd || dma_rdata !== mdl_drd) begin
            n_bad++;
            $display("FAIL rdata cyc=%0d: got cpu=%h dma=%h, need cpu=%h dma=%h", cyc, cpu_rdata, dma_rdata, mdl_crd, mdl_drd);
          end
          if (t.gap) begin
            n_cmp++;
            if (cyc - last_ack != MEM_LAT + 2) begin
              n_bad++;
              $display("FAIL ack_gap cyc=%0d: got %0d, need %0d", cyc, cyc - last_ack, MEM_LAT + 2);
            end
          end
        end
        last_ack = cyc;
      end
      while (prb_q.size() > 0 && prb_q[0].cyc <= cyc) begin
        p = prb_q.pop_front();
        n_cmp++;
        if (p.cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: probe for cyc %0d missed (now %0d)", p.nm, p.cyc, cyc);
        end else if (probe_val(p.sel) !== p.exp) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got %h, need %h", p.nm, cyc, probe_val(p.sel), p.exp);
        end
      end
      if (done && !reported) begin
        n_cmp++;
        if (acc_q.size() + ack_q.size() + prb_q.size() != 0) begin
          n_bad++;
          $display("FAIL leftover: acc=%0d ack=%0d probe=%0d, need 0", acc_q.size(), ack_q.size(), prb_q.size());
        end
        reported = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string nm, input int at, input int sel, input logic [15:0] exp);
    probe_t p;
    p.nm = nm; p.cyc = at; p.sel = sel; p.exp = exp;
    prb_q.push_back(p);
  endtask

  task automatic expect_txn(input bit own, input bit wr, input bit ctrl, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rdata, input bit gap,
                            input bit want_ack);
    txn_t t;
    t.own = own; t.wr = wr; t.ctrl = ctrl; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.gap = gap;
    acc_q.push_back(t);
    if (want_ack) ack_q.push_back(t);
  endtask

  task automatic drive(input bit dma, input bit wr, input bit ctrl, input logic [15:0] addr, input logic [15:0] wdata);
    if (dma) begin
      dma_wr = wr; dma_ctrl = ctrl; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    end else begin
      cpu_wr = wr; cpu_ctrl = ctrl; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit dma);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dma ? dma_ack : cpu_ack) begin
        if (dma) dma_req = 1'b0;
        else     cpu_req = 1'b0;
        return;
      end
    end
    $display("FAIL ack_timeout: no %s ack within 20 cycles", dma ? "dma" : "cpu");
    $fatal(1, "ack timeout");
  endtask

  task automatic do_reset();
    global_reset = 1'b1;
    tick();
    tick();
    global_reset = 1'b0;
  endtask

  initial begin
    int base, acks;
    bit seq[8];
    global_reset = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_ctrl = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_wr = 0; dma_ctrl = 0; dma_addr = '0; dma_wdata = '0;
    tick();
    do_reset();

    // reset state
    probe("rst_busy", cyc, P_BUSY, 16'h0);
    probe("rst_rd", cyc, P_RD, 16'h0);
    probe("rst_wr", cyc, P_WR, 16'h0);
    probe("rst_ackc", cyc, P_ACKC, 16'h0);
    probe("rst_ackd", cyc, P_ACKD, 16'h0);
    probe("rst_own", cyc, P_OWN, 16'h0);
    probe("rst_addr", cyc, P_ADDR, 16'h0);
    probe("rst_wdata", cyc, P_WDATA, 16'h0);
    probe("rst_crd", cyc, P_CRD, 16'h0);
    probe("rst_drd", cyc, P_DRD, 16'h0);
    tick(); tick();

    // CPU word read of 0x0040, cycle-exact timing
    base = cyc;
    drive(0, 0, 1, 16'h0040, 16'h0000);
    expect_txn(0, 0, 1, 16'h0040, 16'h0000, 16'hBEEF, 0, 1);
    probe("t1_rd_c1", base + 1, P_RD, 16'h1);
    probe("t1_addr_c1", base + 1, P_ADDR, 16'h0040);
    probe("t1_ctrl_c1", base + 1, P_CTRL, 16'h1);
    probe("t1_rd_c2", base + 2, P_RD, 16'h1);
    probe("t1_ack_c3", base + 3, P_ACKC, 16'h1);
    probe("t1_rd_c3", base + 3, P_RD, 16'h0);
    probe("t1_crd_c3", base + 3, P_CRD, 16'hBEEF);
    probe("t1_busy_c4", base + 4, P_BUSY, 16'h0);
    wait_ack(0);
    tick(); tick();

    // CPU byte write, DMA idle
    base = cyc;
    drive(0, 1, 0, 16'h0101, 16'h00A5);
    expect_txn(0, 1, 0, 16'h0101, 16'h00A5, 16'h0000, 0, 1);
    probe("t2_wr_c1", base + 1, P_WR, 16'h1);
    probe("t2_rd_c1", base + 1, P_RD, 16'h0);
    probe("t2_ackd_c3", base + 3, P_ACKD, 16'h0);
    wait_ack(0);
    tick(); tick();

    // continuous contention from a fresh reset
    do_reset();
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 1, 0, 0, 0, 1};
`endif
    for (int i = 0; i < 8; i++) begin
      if (seq[i]) expect_txn(1, 1, 1, 16'h2000, 16'h1234, 16'h0000, i > 0, 1);
      else        expect_txn(0, 0, 1, 16'h1000, 16'hFFFF, 16'h4A5A, i > 0, 1);
    end
    drive(0, 0, 1, 16'h1000, 16'hFFFF);
    drive(1, 1, 1, 16'h2000, 16'h1234);
    acks = 0;
    for (int i = 0; i < 8 * (MEM_LAT + 2) + 20 && acks < 8; i++) begin
      tick();
      if (cpu_ack || dma_ack) acks++;
    end
    cpu_req = 0;
    dma_req = 0;
    if (acks < 8) begin
      $display("FAIL contention_timeout: got %0d acks, need 8", acks);
      $fatal(1, "contention timeout");
    end
    tick(); tick();

    // DMA word read so dma_rdata is non-zero before the reset test
    drive(1, 0, 1, 16'h0200, 16'h0000);
    expect_txn(1, 0, 1, 16'h0200, 16'h0000, 16'h585A, 0, 1);
    wait_ack(1);
    tick(); tick();

    // DMA read aborted by reset in its first ACCESS cycle
    base = cyc;
    drive(1, 0, 0, 16'h3000, 16'h0000);
    expect_txn(1, 0, 0, 16'h3000, 16'h0000, 16'h0000, 0, 0);
    probe("t4_busy_c1", base + 1, P_BUSY, 16'h1);
    probe("t4_own_c1", base + 1, P_OWN, 16'h1);
    probe("t4_rd_c1", base + 1, P_RD, 16'h1);
    probe("t4_rd_c2", base + 2, P_RD, 16'h0);
    probe("t4_busy_c2", base + 2, P_BUSY, 16'h0);
    probe("t4_ackd_c2", base + 2, P_ACKD, 16'h0);
    probe("t4_drd_c2", base + 2, P_DRD, 16'h0);
    probe("t4_ackd_c3", base + 3, P_ACKD, 16'h0);
    tick();
    global_reset = 1'b1;
    dma_req = 1'b0;
    tick();
    global_reset = 1'b0;
    tick(); tick(); tick();

    // CPU drops its request mid-access
    base = cyc;
    drive(0, 0, 1, 16'h00FF, 16'h0000);
    expect_txn(0, 0, 1, 16'h00FF, 16'h0000, 16'h5AA5, 0, 1);
    probe("t5_ackc_c3", base + 3, P_ACKC, 16'h1);
    for (int k = 4; k < 9; k++) probe("t5_idle", base + k, P_BUSY, 16'h0);
    tick();
    cpu_req = 1'b0;
    wait_ack(0);
    repeat (8) tick();

    done = 1;
    for (int i = 0; i < 5 && !reported; i++) tick();
    if (!reported) begin
      n_cmp++;
      n_bad++;
      $display("FAIL final_report: monitor did not report");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
